// File: rtl/ccp_pkg.sv
// Shared channel-1 field widths, message types and arbiter state encoding.
// Pure declarations; no latency or flow control of its own.
package ccp_pkg;

    localparam int MSG_WIDTH  = 3;
    localparam int DATA_WIDTH = 32;
    localparam int TAG_WIDTH  = 8;
    localparam int OWNER_BITS = 2;
    localparam int DIR_WIDTH  = 4;

    typedef enum logic [MSG_WIDTH-1:0] {
        MSG1_GETS    = 3'd0,
        MSG1_GETM    = 3'd1,
        MSG1_PUTS    = 3'd2,
        MSG1_PUTM    = 3'd3,
        MSG1_UPGRADE = 3'd4
    } msg1_type_e;

    typedef struct packed {
        msg1_type_e              typ;
        logic [DATA_WIDTH-1:0]   data;
        logic [TAG_WIDTH-1:0]    tag;
        logic [OWNER_BITS-1:0]   source;
    } msg1_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ccp_rr_pick.sv
// Round-robin pick: first eligible index at or above ptr, wrapping to 0.
// Combinational, zero latency; no flow control.
module ccp_rr_pick #(
    parameter int NUM_REQ    = 4,
    parameter int OWNER_BITS = 2
) (
    input  logic [NUM_REQ-1:0]    elig,
    input  logic [OWNER_BITS-1:0] ptr,
    output logic [OWNER_BITS-1:0] grant,
    output logic                  any_valid
);

    // Scan from the farthest offset down so the nearest eligible index wins last.
    always_comb begin
        logic [OWNER_BITS-1:0] idx;
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + OWNER_BITS'(i);
            if (elig[idx]) begin
                grant     = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccp_msg1_arb.sv
// Arbitrates per-cache one-entry ingress buffers onto the L2 channel-1 port; CCP_ARB_PRIO0_EN gives requester 0 strict priority.
// Latency: accept at edge t, msg1_valid from edge t+1. Backpressure: msg1_ready low holds the output; full buffers drop req_ready.
module ccp_msg1_arb
    import ccp_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int OWNER_BITS = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*MSG_WIDTH-1:0]    req_type,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag,
    output logic                            msg1_valid,
    input  logic                            msg1_ready,
    output logic [MSG_WIDTH-1:0]            msg1_type,
    output logic [DATA_WIDTH-1:0]           msg1_data,
    output logic [TAG_WIDTH-1:0]            msg1_tag,
    output logic [OWNER_BITS-1:0]           msg1_source,
    input  logic                            resp_valid,
    input  logic [OWNER_BITS-1:0]           resp_dest,
    output logic [NUM_REQ-1:0]              outstanding,
    output logic                            err_resp
);

    msg1_t                  buf_q [NUM_REQ];
    logic [NUM_REQ-1:0]     buf_v;
    logic [NUM_REQ-1:0]     outstanding_q;
    logic [NUM_REQ-1:0]     elig;
    logic [OWNER_BITS-1:0]  ptr;
    logic [OWNER_BITS-1:0]  grant;
    logic                   any_elig;
    logic                   ptr_upd;
    logic                   load;
    arb_state_t             state;
    msg1_t                  out_q;
    logic                   valid_q;
    logic                   err_q;

    assign elig = buf_v & ~outstanding_q;

`ifdef CCP_ARB_PRIO0_EN
    logic [OWNER_BITS-1:0] rr_grant;
    logic                  rr_any;

    ccp_rr_pick #(.NUM_REQ(NUM_REQ), .OWNER_BITS(OWNER_BITS)) u_pick (
        .elig      ({elig[NUM_REQ-1:1], 1'b0}),
        .ptr       (ptr),
        .grant     (rr_grant),
        .any_valid (rr_any)
    );

    // Requester 0 bypasses the rotation and leaves the pointer untouched.
    assign grant    = elig[0] ? '0 : rr_grant;
    assign any_elig = elig[0] | rr_any;
    assign ptr_upd  = ~elig[0];
`else
    ccp_rr_pick #(.NUM_REQ(NUM_REQ), .OWNER_BITS(OWNER_BITS)) u_pick (
        .elig      (elig),
        .ptr       (ptr),
        .grant     (grant),
        .any_valid (any_elig)
    );

    assign ptr_upd = 1'b1;
`endif

    // In SEND a new grant may only load on the edge that hands off the current one.
    assign load = any_elig & ((state == IDLE) | msg1_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_q[i] <= '0;
            end
            buf_v         <= '0;
            outstanding_q <= '0;
            ptr           <= '0;
            state         <= IDLE;
            out_q         <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !buf_v[i]) begin
                    buf_v[i] <= 1'b1;
                    buf_q[i] <= '{typ:    msg1_type_e'(req_type[i*MSG_WIDTH +: MSG_WIDTH]),
                                  data:   req_data[i*DATA_WIDTH +: DATA_WIDTH],
                                  tag:    req_tag[i*TAG_WIDTH +: TAG_WIDTH],
                                  source: OWNER_BITS'(i)};
                end
            end

            if (resp_valid) begin
                if (outstanding_q[resp_dest]) begin
                    outstanding_q[resp_dest] <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end

            // A grant never targets resp_dest: elig already excludes outstanding requesters.
            if (load) begin
                buf_v[grant]         <= 1'b0;
                outstanding_q[grant] <= 1'b1;
                out_q                <= buf_q[grant];
                if (ptr_upd) begin
                    ptr <= grant + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (load) begin
                        state   <= SEND;
                        valid_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (msg1_ready && !any_elig) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign req_ready   = ~buf_v;
    assign msg1_valid  = valid_q;
    assign msg1_type   = out_q.typ;
    assign msg1_data   = out_q.data;
    assign msg1_tag    = out_q.tag;
    assign msg1_source = out_q.source;
    assign outstanding = outstanding_q;
    assign err_resp    = err_q;

endmodule

// File: tb/tb_ccp_msg1_arb.sv
// Directed bench for ccp_msg1_arb: scoreboard of expected channel-1 handshakes plus state checks.
module tb_ccp_msg1_arb;
    import ccp_pkg::*;

    localparam int N = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [N-1:0]               req_valid;
    logic [N-1:0]               req_ready;
    logic [N*MSG_WIDTH-1:0]     req_type;
    logic [N*DATA_WIDTH-1:0]    req_data;
    logic [N*TAG_WIDTH-1:0]     req_tag;
    logic                       msg1_valid;
    logic                       msg1_ready;
    logic [MSG_WIDTH-1:0]       msg1_type;
    logic [DATA_WIDTH-1:0]      msg1_data;
    logic [TAG_WIDTH-1:0]       msg1_tag;
    logic [OWNER_BITS-1:0]      msg1_source;
    logic                       resp_valid;
    logic [OWNER_BITS-1:0]      resp_dest;
    logic [N-1:0]               outstanding;
    logic                       err_resp;

    ccp_msg1_arb #(.NUM_REQ(N), .OWNER_BITS(OWNER_BITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_type    (req_type),
        .req_data    (req_data),
        .req_tag     (req_tag),
        .msg1_valid  (msg1_valid),
        .msg1_ready  (msg1_ready),
        .msg1_type   (msg1_type),
        .msg1_data   (msg1_data),
        .msg1_tag    (msg1_tag),
        .msg1_source (msg1_source),
        .resp_valid  (resp_valid),
        .resp_dest   (resp_dest),
        .outstanding (outstanding),
        .err_resp    (err_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OWNER_BITS-1:0] src;
        logic [7:0]            tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every channel-1 handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && msg1_valid === 1'b1 && msg1_ready === 1'b1) begin
            chk("hs_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("hs_source", 32'(msg1_source), 32'(mon_e.src));
                chk("hs_tag",    32'(msg1_tag),    32'(mon_e.tag));
                chk("hs_data",   msg1_data,        {4{mon_e.tag}});
                chk("hs_type",   32'(msg1_type),   32'(MSG1_GETM));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_hs(input int src, input logic [7:0] tag);
        exp_t e;
        e.src = OWNER_BITS'(src);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic drive_req(input int i, input logic [7:0] tag);
        req_valid[i]                          = 1'b1;
        req_type[i*MSG_WIDTH +: MSG_WIDTH]    = MSG1_GETM;
        req_data[i*DATA_WIDTH +: DATA_WIDTH]  = {4{tag}};
        req_tag[i*TAG_WIDTH +: TAG_WIDTH]     = tag;
    endtask

    // Requester i presents tag base+i for exactly one edge.
    task automatic push(input logic [N-1:0] mask, input logic [7:0] base);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) drive_req(i, base + 8'(i));
        end
        tick();
        req_valid = '0;
    endtask

    task automatic resp(input int d);
        resp_valid = 1'b1;
        resp_dest  = OWNER_BITS'(d);
        tick();
        resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        req_valid  = '0;
        resp_valid = 1'b0;
        rst        = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    int          ord  [5];
    logic [7:0]  otag [5];

    initial begin
        rst        = 1'b0;
        req_valid  = '0;
        req_type   = '0;
        req_data   = '0;
        req_tag    = '0;
        msg1_ready = 1'b1;
        resp_valid = 1'b0;
        resp_dest  = '0;
        tick();
        tick();

        chk("rst_req_ready",   32'(req_ready),   32'hf);
        chk("rst_msg1_valid",  32'(msg1_valid),  32'd0);
        chk("rst_msg1_tag",    32'(msg1_tag),    32'd0);
        chk("rst_msg1_source", 32'(msg1_source), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err_resp",    32'(err_resp),    32'd0);
        rst = 1'b1;
        tick();

        // Single request from requester 2.
        expect_hs(2, 8'h15);
        push(4'b0100, 8'h13);
        chk("single_valid_t0", 32'(msg1_valid),  32'd0);
        chk("single_ready_t0", 32'(req_ready),   32'b1011);
        tick();
        chk("single_valid_t1", 32'(msg1_valid),  32'd1);
        chk("single_source",   32'(msg1_source), 32'd2);
        chk("single_tag",      32'(msg1_tag),    32'h15);
        chk("single_outst",    32'(outstanding), 32'b0100);
        chk("single_ready_t1", 32'(req_ready),   32'hf);
        tick();
        chk("single_drained",  32'(msg1_valid),  32'd0);
        chk("single_sb_empty", 32'(exp_q.size()), 32'd0);
        resp(2);
        chk("single_outst_clr", 32'(outstanding), 32'd0);
        chk("single_err",       32'(err_resp),    32'd0);

        // Fairness: all four at once, immediate responses, requester 0 re-requests.
        do_reset();
`ifdef CCP_ARB_PRIO0_EN
        ord  = '{0, 1, 0, 2, 3};
        otag = '{8'h20, 8'h21, 8'h30, 8'h22, 8'h23};
`else
        ord  = '{0, 1, 2, 3, 0};
        otag = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h30};
`endif
        for (int k = 0; k < 5; k++) expect_hs(ord[k], otag[k]);
        push(4'hf, 8'h20);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("fair_valid",  32'(msg1_valid),  32'd1);
            chk("fair_source", 32'(msg1_source), 32'(ord[k]));
            resp_valid = 1'b1;
            resp_dest  = msg1_source;
            if (k == 0) drive_req(0, 8'h30);
            tick();
            req_valid = '0;
        end
        resp_valid = 1'b0;
        chk("fair_idle",     32'(msg1_valid),    32'd0);
        chk("fair_outst",    32'(outstanding),   32'd0);
        chk("fair_err",      32'(err_resp),      32'd0);
        chk("fair_sb_empty", 32'(exp_q.size()),  32'd0);

        // Back-pressure: output held for 10 cycles, then drain.
        do_reset();
        msg1_ready = 1'b0;
        for (int i = 0; i < N; i++) expect_hs(i, 8'h40 + 8'(i));
        push(4'hf, 8'h40);
        tick();
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid",  32'(msg1_valid),  32'd1);
            chk("bp_source", 32'(msg1_source), 32'd0);
            chk("bp_tag",    32'(msg1_tag),    32'h40);
            chk("bp_ready",  32'(req_ready),   32'b0001);
            tick();
        end
        msg1_ready = 1'b1;
        repeat (4) tick();
        chk("bp_idle",     32'(msg1_valid),   32'd0);
        chk("bp_outst",    32'(outstanding),  32'hf);
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Full: every buffer loaded while every requester is outstanding.
        expect_hs(1, 8'h51);
        expect_hs(2, 8'h52);
        expect_hs(3, 8'h53);
        expect_hs(0, 8'h50);
        push(4'hf, 8'h50);
        tick();
        chk("full_ready", 32'(req_ready),  32'd0);
        chk("full_valid", 32'(msg1_valid), 32'd0);
        tick();
        chk("full_ready2", 32'(req_ready),  32'd0);
        chk("full_valid2", 32'(msg1_valid), 32'd0);
        resp(1);
        resp(2);
        resp(3);
        resp(0);
        tick();
        tick();
        chk("full_idle",     32'(msg1_valid),   32'd0);
        chk("full_outst",    32'(outstanding),  32'hf);
        chk("full_sb_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < N; i++) resp(i);
        chk("full_outst_clr", 32'(outstanding), 32'd0);

        // Outstanding block: second request from 1 waits, requester 3 goes first.
        do_reset();
        expect_hs(1, 8'h61);
        expect_hs(3, 8'h73);
        expect_hs(1, 8'h71);
        push(4'b0010, 8'h60);
        tick();
        push(4'b1010, 8'h70);
        repeat (4) tick();
        chk("blk_outst", 32'(outstanding), 32'b1010);
        chk("blk_valid", 32'(msg1_valid),  32'd0);
        chk("blk_ready", 32'(req_ready),   32'b1101);
        resp(1);
        tick();
        chk("blk_regrant_valid", 32'(msg1_valid),  32'd1);
        chk("blk_regrant_src",   32'(msg1_source), 32'd1);
        chk("blk_regrant_tag",   32'(msg1_tag),    32'h71);
        tick();
        chk("blk_outst2",    32'(outstanding),  32'b1010);
        chk("blk_sb_empty",  32'(exp_q.size()), 32'd0);
        resp(1);
        resp(3);
        chk("blk_outst_clr", 32'(outstanding), 32'd0);

        // Spurious response.
        chk("spur_err_pre", 32'(err_resp), 32'd0);
        resp(0);
        chk("spur_err",   32'(err_resp),    32'd1);
        chk("spur_outst", 32'(outstanding), 32'd0);
        chk("spur_ready", 32'(req_ready),   32'hf);
        chk("spur_valid", 32'(msg1_valid),  32'd0);
        tick();
        chk("spur_sticky", 32'(err_resp), 32'd1);

        // Asynchronous reset while a message is being held.
        msg1_ready = 1'b0;
        push(4'b0100, 8'h75);
        tick();
        chk("mid_valid", 32'(msg1_valid),  32'd1);
        chk("mid_outst", 32'(outstanding), 32'b0100);
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(msg1_valid),  32'd0);
        chk("arst_outst", 32'(outstanding), 32'd0);
        chk("arst_ready", 32'(req_ready),   32'hf);
        chk("arst_err",   32'(err_resp),    32'd0);
        chk("arst_tag",   32'(msg1_tag),    32'd0);
        tick();
        rst = 1'b1;
        msg1_ready = 1'b1;
        tick();
        tick();
        chk("arst_no_replay", 32'(msg1_valid),   32'd0);
        chk("end_sb_empty",   32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
